// File: rtl/ehgu_rr_arb.sv
// ehgu_rr_arb: round-robin arbiter with grant hold, idle gap between owners and watchdog timeout
module ehgu_rr_arb #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_vld,
    output logic [ID_W-1:0]    gnt_id,
    output logic               timeout,
    output logic               busy
);
    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t             state, state_n;
    logic [ID_W-1:0]    last_ptr, win;
    logic [HW-1:0]      hold_cnt;
    logic [NUM_REQ-1:0] block_mask, elig;
    logic               found, owner_req, expire, revoke;

    assign elig      = req & ~block_mask;
    assign owner_req = req[gnt_id];
    assign expire    = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
    assign revoke    = (state == GRANT) && owner_req && expire;
    assign gnt_vld   = |gnt;
    assign busy      = state != IDLE;

    // Rotating priority search starting just after the last owner; the smallest offset wins
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (elig[(int'(last_ptr) + k) % NUM_REQ]) begin
                win   = ID_W'((int'(last_ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    // Next state: an owner drop beats a timeout, and RELEASE always returns to IDLE
    always_comb begin
        state_n = state;
        state_n = (state == IDLE)  ? (found ? GRANT : IDLE) :
                  (state == GRANT) ? ((!owner_req || expire) ? RELEASE : GRANT) : IDLE;
    end

    // Grant, ownership bookkeeping and timeout mask registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            gnt_id     <= '0;
            timeout    <= 1'b0;
            last_ptr   <= ID_W'(NUM_REQ - 1);
            hold_cnt   <= '0;
            block_mask <= '0;
        end else begin
            state      <= state_n;
            timeout    <= revoke;
            block_mask <= (block_mask & req) | (revoke ? NUM_REQ'(1) << gnt_id : '0);
            if (state == IDLE && found) begin
                gnt      <= NUM_REQ'(1) << win;
                gnt_id   <= win;
                last_ptr <= win;
                hold_cnt <= HW'(1);
            end else if (state == GRANT && (!owner_req || expire)) begin
                gnt <= '0;
            end else if (state == GRANT && hold_cnt != '1) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end
endmodule

// File: doc/ehgu_rr_arb.md
Name: ehgu_rr_arb

Overview:
- Round-robin arbiter with grant-hold and a watchdog timeout.
- Shares one ehgu datapath resource, e.g. a shared edge-detect or code-converter lane, among NUM_REQ requesters.
- Grants are registered and one-hot, and are held while the owner keeps its request high.
- A mandatory idle cycle separates any two grants, so downstream can reset its state between owners.

Parameters:
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- MAX_HOLD, default 16: maximum consecutive grant cycles per ownership; 0 disables the timeout.
- ID_W, default $clog2(NUM_REQ): width of gnt_id.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester request level; bit i belongs to requester i.
- gnt  out  NUM_REQ  registered one-hot grant; all zero when no owner.
- gnt_vld  out  1  high whenever any gnt bit is high, i.e. |gnt.
- gnt_id  out  ID_W  index of the current owner; holds the last owner when gnt_vld=0.
- timeout  out  1  one-cycle pulse when an ownership is revoked by MAX_HOLD.
- busy  out  1  high in GRANT and RELEASE states.

Behaviour:
- Reset values (rst=1 at a clk edge): state=IDLE, gnt=0, gnt_vld=0, gnt_id=0, timeout=0, busy=0, last_ptr=NUM_REQ-1, hold_cnt=0, block_mask=0.
- Eligible set: elig = req & ~block_mask.
- Priority: search elig starting at index last_ptr+1 and wrap modulo NUM_REQ. After reset, requester 0 has highest priority.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE: if elig!=0 in cycle N, then in cycle N+1: gnt=onehot(winner), gnt_id=winner, last_ptr=winner, hold_cnt=1, state=GRANT. The latency from req to gnt is exactly 1 cycle. If elig=0, stay in IDLE.
- GRANT, normal release: if req[gnt_id]=0, next cycle gnt=0 and state=RELEASE.
- GRANT, timeout (MAX_HOLD!=0): if req[gnt_id]=1 and hold_cnt==MAX_HOLD, next cycle:
  - gnt=0;
  - timeout=1 for that one cycle;
  - block_mask[gnt_id]=1;
  - state=RELEASE.
- GRANT, otherwise: hold the grant and increment hold_cnt. hold_cnt saturates, so with MAX_HOLD=0 it never wraps back into a timeout.
- Grant length: the owner holds gnt for exactly MAX_HOLD cycles before revocation.
- RELEASE: lasts exactly 1 cycle with gnt=0, then IDLE. Arbitration in IDLE uses that cycle's req, so back-to-back owners show a 1-cycle gnt gap plus 1 cycle of IDLE latency.
- Block mask: block_mask[i] clears in any cycle where req[i]=0. A timed-out requester must drop req for at least 1 cycle before it is eligible again.
- Requests in other states: req changes from non-owners during GRANT/RELEASE are ignored. They are sampled only in IDLE.
- Simultaneous owner drop and hold_cnt==MAX_HOLD: the release wins. No timeout pulse, no mask.
- One-hot invariant: gnt is never more than one-hot, and it never changes owner without passing through gnt=0.
- rst mid-grant: gnt drops on the next edge and all state returns to its reset values, including last_ptr and block_mask.
- Width rules: hold_cnt width is $clog2(MAX_HOLD+1), minimum 1. last_ptr+1 wraps to 0 at NUM_REQ-1, which is also correct for non-power-of-2 NUM_REQ.

Test Plan:
1. Reset priority (NUM_REQ=4): rst, then req=4'b1111 held → gnt=0001 one cycle after req. Each owner drops req after 3 cycles and re-raises it → grant order 0,1,2,3,0, with a ≥2-cycle gnt=0 gap between grants.
2. Single requester: req=4'b0100 for 5 cycles, then 0 → gnt=0100 for 5 cycles starting 1 cycle after req, gnt_id=2. After req drops, gnt=0 and busy stays high 1 more cycle (RELEASE), then low.
3. Timeout (MAX_HOLD=16): req=4'b0010 held for 40 cycles → gnt=0010 for exactly 16 cycles, then timeout=1 for one cycle. No regrant to requester 1 for the rest of the 40 cycles. After req drops 1 cycle and rises again → regrant.
4. Timeout with competitor: req[1] held, req[3] raised at cycle 5 → after requester 1 times out, requester 3 is granted in the cycle after the RELEASE cycle. Requester 1 stays blocked.
5. Boundary: owner drops req in the same cycle hold_cnt==16 → gnt drops, timeout stays 0, and the owner is immediately eligible again.
6. Reset mid-operation: rst asserted during GRANT of requester 2 → next edge gnt=0, gnt_id=0, busy=0. With req=4'b1100 after reset → requester 2 wins, because last_ptr=3 makes the search start at index 0.
